// File: rtl/bcd_to_binary.sv
// bcd_to_binary: registered BCD-to-seven-segment decoder for one display digit.
// Purpose : converts a 4-bit code into seven cathode drive bits with a fixed
//           one-cycle latency. Codes 0-9 give digit glyphs; codes 10-15 give
//           a dash or hex glyphs A b C d E F depending on HEX_EN.
// Params  : ACTIVE_LOW - 1: lit segment driven 0 (common anode), 0: driven 1
//           HEX_EN     - 1: hex glyphs for 10-15, 0: dash for 10-15
// Ports   : clk   - system clock, rising edge
//           reset - synchronous active-high reset, loads blank into seg
//           bcd   - digit code to display
//           seg   - registered segment drive, seg[0]=a .. seg[6]=g
module bcd_to_binary #(
   parameter bit ACTIVE_LOW = 1'b1,
   parameter bit HEX_EN     = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   localparam int unsigned SEG_W = 7;

   // All segments off in the selected polarity.
   localparam logic [SEG_W-1:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

   // Dash shown for codes 10-15 when hex glyphs are disabled.
   localparam logic [SEG_W-1:0] DASH = 7'h40;

   logic [SEG_W-1:0] glyph_c;   // active-high glyph for the current code
   logic [SEG_W-1:0] drive_c;   // glyph in output polarity

   // Active-high glyph lookup.
   always_comb begin
      glyph_c = DASH;
      unique case (bcd)
         4'd0:  glyph_c = 7'h3F;
         4'd1:  glyph_c = 7'h06;
         4'd2:  glyph_c = 7'h5B;
         4'd3:  glyph_c = 7'h4F;
         4'd4:  glyph_c = 7'h66;
         4'd5:  glyph_c = 7'h6D;
         4'd6:  glyph_c = 7'h7D;
         4'd7:  glyph_c = 7'h07;
         4'd8:  glyph_c = 7'h7F;
         4'd9:  glyph_c = 7'h6F;
         4'd10: glyph_c = HEX_EN ? 7'h77 : DASH;
         4'd11: glyph_c = HEX_EN ? 7'h7C : DASH;
         4'd12: glyph_c = HEX_EN ? 7'h39 : DASH;
         4'd13: glyph_c = HEX_EN ? 7'h5E : DASH;
         4'd14: glyph_c = HEX_EN ? 7'h79 : DASH;
         4'd15: glyph_c = HEX_EN ? 7'h71 : DASH;
         default: glyph_c = DASH;
      endcase
   end

   // Polarity selection.
   always_comb begin
      drive_c = glyph_c;
      if (ACTIVE_LOW) begin
         drive_c = ~glyph_c;
      end
   end

   // Output register; reset wins over any code.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg <= BLANK;
      end else begin
         seg <= drive_c;
      end
   end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: self-checking bench for bcd_to_binary.
// Four builds (all parameter combinations) share clk, reset and bcd. Directed
// steps check spec values; random steps check against a letter-based glyph model.
module tb_bcd_to_binary;

   logic       clk;
   logic       reset;
   logic [3:0] bcd;
   logic [6:0] seg_def;   // ACTIVE_LOW=1 HEX_EN=0
   logic [6:0] seg_hex;   // ACTIVE_LOW=0 HEX_EN=1
   logic [6:0] seg_pos;   // ACTIVE_LOW=0 HEX_EN=0
   logic [6:0] seg_alh;   // ACTIVE_LOW=1 HEX_EN=1

   int total;
   int bad;

   bcd_to_binary #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) dut_def (.clk(clk), .reset(reset), .bcd(bcd), .seg(seg_def));
   bcd_to_binary #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) dut_hex (.clk(clk), .reset(reset), .bcd(bcd), .seg(seg_hex));
   bcd_to_binary #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) dut_pos (.clk(clk), .reset(reset), .bcd(bcd), .seg(seg_pos));
   bcd_to_binary #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) dut_alh (.clk(clk), .reset(reset), .bcd(bcd), .seg(seg_alh));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Glyphs described by lit segment letters.
   function automatic string glyph_letters(input int code, input bit hex);
      string digits [10];
      string hexes  [6];
      digits = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                 "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
      hexes  = '{"abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
      if (code < 10) return digits[code];
      if (hex)       return hexes[code - 10];
      return "g";
   endfunction

   function automatic logic [6:0] model(input bit al, input bit hex, input bit rst, input int code);
      logic [6:0] lit;
      string      s;
      lit = 7'h00;
      if (!rst) begin
         s = glyph_letters(code, hex);
         for (int i = 0; i < s.len(); i++) begin
            lit[int'(s[i]) - 97] = 1'b1;
         end
      end
      return al ? ~lit : lit;
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check every build against the model for the inputs applied at the last edge.
   task automatic chk_all(input string tag, input bit rst, input int code);
      chk({tag, "_def"}, seg_def, model(1'b1, 1'b0, rst, code));
      chk({tag, "_hex"}, seg_hex, model(1'b0, 1'b1, rst, code));
      chk({tag, "_pos"}, seg_pos, model(1'b0, 1'b0, rst, code));
      chk({tag, "_alh"}, seg_alh, model(1'b1, 1'b1, rst, code));
   endtask

   // Apply inputs, take one rising edge, settle.
   task automatic step(input bit rst, input logic [3:0] code);
      reset = rst;
      bcd   = code;
      @(posedge clk);
      #1;
   endtask

   logic [6:0] def_digits [10];
   logic [6:0] pos_digits [10];
   logic [6:0] hex_glyphs [6];
   bit         r;
   logic [3:0] c;

   initial begin
      total = 0;
      bad   = 0;
      def_digits = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      pos_digits = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      hex_glyphs = '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      reset = 1'b1;
      bcd   = 4'd8;
      #2;

      // Reset held two edges with bcd=8 gives blank.
      step(1'b1, 4'd8);
      step(1'b1, 4'd8);
      chk("reset_def", seg_def, 7'h7F);
      chk("reset_pos", seg_pos, 7'h00);
      chk("reset_hex", seg_hex, 7'h00);
      chk("reset_alh", seg_alh, 7'h7F);

      // First edge after release loads decoded 8.
      step(1'b0, 4'd8);
      chk("release_def", seg_def, 7'h00);
      chk("release_pos", seg_pos, 7'h7F);

      // Digit sweep, both polarities.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 4'(i));
         chk($sformatf("sweep_def_%0d", i), seg_def, def_digits[i]);
         chk($sformatf("sweep_pos_%0d", i), seg_pos, pos_digits[i]);
      end

      // Codes 10-15: dash without hex, glyphs with hex.
      for (int i = 10; i < 16; i++) begin
         step(1'b0, 4'(i));
         chk($sformatf("dash_def_%0d", i), seg_def, 7'h3F);
         chk($sformatf("dash_pos_%0d", i), seg_pos, 7'h40);
         chk($sformatf("hex_%0d", i), seg_hex, hex_glyphs[i - 10]);
         chk($sformatf("hex_al_%0d", i), seg_alh, ~hex_glyphs[i - 10]);
      end

      // Mid-cycle change is invisible until the next edge.
      step(1'b0, 4'd1);
      chk("mid_before", seg_def, 7'h79);
      #3 bcd = 4'd7;
      #1 chk("mid_hold", seg_def, 7'h79);
      @(posedge clk);
      #1 chk("mid_after", seg_def, 7'h78);

      // Repeated code holds the output.
      step(1'b0, 4'd7);
      chk("hold_def", seg_def, 7'h78);

      // Reset together with a code change.
      step(1'b1, 4'd3);
      chk("rst_change_def", seg_def, 7'h7F);
      chk("rst_change_pos", seg_pos, 7'h00);

      // Random codes with occasional reset.
      for (int n = 0; n < 200; n++) begin
         r = ($urandom_range(0, 7) == 0);
         c = 4'($urandom_range(0, 15));
         step(r, c);
         chk_all($sformatf("rand%0d", n), r, int'(c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
